// File: rtl/ahead_adder16_pkg.sv
// ----------------------------------------------------------------------------
// ahead_adder16_pkg
//   Shared sizing constants and types for the 16-bit two-level carry-lookahead
//   adder (ahead_adder16) and its 4-bit group slice (cla4).
//
//   WIDTH   operand width (16). The lookahead tree is hand-built for this size.
//   GROUP   bits per first-level lookahead group (4).
//   NGROUPS number of first-level groups (4).
//
//   Optional build macro used by the top level: AHEAD_ADDER16_OVF_EN.
// ----------------------------------------------------------------------------
package ahead_adder16_pkg;

  localparam int WIDTH   = 16;
  localparam int GROUP   = 4;
  localparam int NGROUPS = WIDTH / GROUP;

  typedef logic [WIDTH-1:0] word_t;

  // One registered adder result: carry out plus sum bits.
  typedef struct packed {
    logic  cout;
    word_t s;
  } sum_t;

endpackage : ahead_adder16_pkg

// File: rtl/ahead_adder16_cla4.sv
// ----------------------------------------------------------------------------
// cla4
//   4-bit first-level carry-lookahead group. All in-group carries are flat
//   sum-of-products of this group's g/p and its carry-in, so no bit waits on
//   a neighbour's carry. Also exports group generate/propagate so the top
//   level can compute group carries without waiting for this group's sum.
//
//   Ports
//     a[3:0], b[3:0]  in   operand slices
//     ci              in   group carry-in
//     s[3:0]          out  sum slice
//     gg              out  group generate  (group produces a carry by itself)
//     gp              out  group propagate (group passes ci straight through)
// ----------------------------------------------------------------------------
module cla4
  import ahead_adder16_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             gg,
  output logic             gp
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;

    // Flat lookahead inside the group; c[i] is the carry into bit i.
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);

    s = p ^ c;

    // Group terms exclude ci so the second level can combine them directly.
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
    gp = &p;
  end

endmodule : cla4

// File: rtl/ahead_adder16.sv
// ----------------------------------------------------------------------------
// ahead_adder16
//   16-bit two-level carry-lookahead adder: {cout,S} = A + B + CIN, purely
//   combinational, plus a one-cycle registered copy for synchronous users.
//
//   Ports
//     clk     in   1   clock for the registered copy only
//     rst_n   in   1   async active-low reset, clears S_q/cout_q(/ovf_q)
//     A, B    in   16  unsigned operands
//     CIN     in   1   carry in
//     S       out  16  combinational sum
//     cout    out  1   combinational carry out (sum bit 16)
//     S_q     out  16  S registered on posedge clk
//     cout_q  out  1   cout registered on posedge clk
//     ovf     out  1   signed overflow      (AHEAD_ADDER16_OVF_EN builds only)
//     ovf_q   out  1   ovf registered       (AHEAD_ADDER16_OVF_EN builds only)
//
//   Build option: define AHEAD_ADDER16_OVF_EN to add the signed-overflow flag
//   and its registered copy. Without it those ports and their logic do not
//   exist; everything else is unchanged.
// ----------------------------------------------------------------------------
module ahead_adder16
  import ahead_adder16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  word_t       A,
  input  word_t       B,
  input  logic        CIN,
  output word_t       S,
  output logic        cout,
  output word_t       S_q,
  output logic        cout_q
`ifdef AHEAD_ADDER16_OVF_EN
  ,
  output logic        ovf,
  output logic        ovf_q
`endif
);

  // --------------------------------------------------------------------------
  // First level: four 4-bit lookahead groups. gc[k] is the carry into group k;
  // gc[NGROUPS] is the final carry out.
  // --------------------------------------------------------------------------
  logic [NGROUPS-1:0] gg;
  logic [NGROUPS-1:0] gp;
  logic [NGROUPS:0]   gc;

  // Instance array: A/B/S are split into GROUP-bit slices, one per instance.
  cla4 u_grp [NGROUPS-1:0] (
    .a  (A),
    .b  (B),
    .ci (gc[NGROUPS-1:0]),
    .s  (S),
    .gg (gg),
    .gp (gp)
  );

  // --------------------------------------------------------------------------
  // Second level: every group carry is a flat sum-of-products of GG/GP and CIN.
  // Nothing here depends on another group carry, so there is no ripple between
  // groups; C16 has the same depth as C4 plus one wider OR.
  // --------------------------------------------------------------------------
  always_comb begin
    gc[0] = CIN;
    gc[1] = gg[0] | (gp[0] & CIN);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & CIN);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & CIN);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & CIN);
  end

  assign cout = gc[NGROUPS];

  // --------------------------------------------------------------------------
  // Registered copy. No enable: it follows the combinational result every edge.
  // --------------------------------------------------------------------------
  sum_t sum_d;
  sum_t sum_q;

  always_comb begin
    sum_d.cout = cout;
    sum_d.s    = S;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign S_q    = sum_q.s;
  assign cout_q = sum_q.cout;

`ifdef AHEAD_ADDER16_OVF_EN
  // --------------------------------------------------------------------------
  // Signed overflow: operands agree in sign but the sum does not.
  // --------------------------------------------------------------------------
  logic ovf_d;
  logic ovf_r_q;

  always_comb begin
    ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);
    ovf_d = ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_r_q <= 1'b0;
    else        ovf_r_q <= ovf_d;
  end

  assign ovf_q = ovf_r_q;
`endif

endmodule : ahead_adder16

// File: tb/tb_ahead_adder16.sv
// ----------------------------------------------------------------------------
// tb_ahead_adder16
//   Self-checking bench for ahead_adder16. Expected sums come from a 17-bit
//   behavioural add pushed into scoreboards when the inputs are driven; the
//   combinational and registered outputs pop and compare against them.
// ----------------------------------------------------------------------------
module tb_ahead_adder16;
  import ahead_adder16_pkg::*;

  logic  clk;
  logic  rst_n;
  word_t A, B;
  logic  CIN;
  word_t S, S_q;
  logic  cout, cout_q;
`ifdef AHEAD_ADDER16_OVF_EN
  logic  ovf, ovf_q;
`endif

  ahead_adder16 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .CIN    (CIN),
    .S      (S),
    .cout   (cout),
    .S_q    (S_q),
    .cout_q (cout_q)
`ifdef AHEAD_ADDER16_OVF_EN
    ,
    .ovf    (ovf),
    .ovf_q  (ovf_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [16:0] comb_q[$];
  logic [16:0] reg_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Drive operands and record the reference sum for later comparison.
  task automatic apply(input word_t a, input word_t b, input logic c, input bit reg_chk);
    logic [16:0] e;
    A = a; B = b; CIN = c;
    e = {1'b0, a} + {1'b0, b} + {16'd0, c};
    comb_q.push_back(e);
    if (reg_chk) reg_q.push_back(e);
  endtask

  task automatic check_comb(input string tag);
    logic [16:0] e;
    if (comb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = comb_q.pop_front();
      chk(tag, {15'd0, cout, S}, {15'd0, e});
    end
  endtask

  task automatic check_reg(input string tag);
    logic [16:0] e;
    if (reg_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = reg_q.pop_front();
      chk(tag, {15'd0, cout_q, S_q}, {15'd0, e});
    end
  endtask

  typedef struct {
    word_t a;
    word_t b;
    logic  c;
    logic  ov;
    string tag;
  } vec_t;

  vec_t dir[$];

  initial begin
    int bad0;
    int passes;
    word_t ra, rb;

    dir.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, "zero"});
    dir.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, "wrap_ffff_1"});
    dir.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "ffff_ffff_c1"});
    dir.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, "grp_boundary"});
    dir.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b1, "ovf_pos"});
    dir.push_back('{16'h8000, 16'h8000, 1'b0, 1'b1, "ovf_neg"});
    dir.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, "no_ovf"});
    dir.push_back('{16'h0FFF, 16'h0000, 1'b1, 1'b0, "cin_chain12"});
    dir.push_back('{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, "alt_c1"});

    // Reset state
    rst_n = 1'b0; A = '0; B = '0; CIN = 1'b0;
    #2;
    chk("reset_S_q", {16'd0, S_q}, 32'd0);
    chk("reset_cout_q", {31'd0, cout_q}, 32'd0);
`ifdef AHEAD_ADDER16_OVF_EN
    chk("reset_ovf_q", {31'd0, ovf_q}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors through both the comb and registered paths
    foreach (dir[i]) begin
      @(negedge clk);
      apply(dir[i].a, dir[i].b, dir[i].c, 1'b1);
      #1;
      check_comb({dir[i].tag, "_comb"});
`ifdef AHEAD_ADDER16_OVF_EN
      chk({dir[i].tag, "_ovf"}, {31'd0, ovf}, {31'd0, dir[i].ov});
`endif
      @(posedge clk);
      #1;
      check_reg({dir[i].tag, "_reg"});
`ifdef AHEAD_ADDER16_OVF_EN
      chk({dir[i].tag, "_ovf_q"}, {31'd0, ovf_q}, {31'd0, dir[i].ov});
`endif
    end

    // Mid-operation reset: registers clear at once, comb path unaffected
    @(negedge clk);
    apply(16'h1234, 16'h1111, 1'b0, 1'b1);
    #1;
    check_comb("rst_pre_comb");
    @(posedge clk);
    #1;
    check_reg("rst_pre_reg");
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_S_q", {16'd0, S_q}, 32'd0);
    chk("rst_mid_cout_q", {31'd0, cout_q}, 32'd0);
    chk("rst_mid_S", {15'd0, cout, S}, 32'h0000_2345);
    #1;
    rst_n = 1'b1;
    reg_q.push_back(17'h02345);
    @(posedge clk);
    #1;
    check_reg("rst_release_reg");

    // Sweep: exhaustive over the low 7 bits of each operand with CIN=0
    bad0   = bad;
    passes = 0;
    for (int a = 0; a < 128; a++) begin
      for (int b = 0; b < 128; b++) begin
        apply(word_t'(a), word_t'(b), 1'b0, 1'b0);
        #1;
        check_comb("sweep_lo");
        if (bad != bad0) break;
        passes++;
      end
      if (bad != bad0) break;
    end

    // Random full-width samples, mostly CIN=1
    if (bad == bad0) begin
      for (int i = 0; i < 4000; i++) begin
        ra = word_t'($urandom);
        rb = word_t'($urandom);
        apply(ra, rb, (i < 3000) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
        #1;
        check_comb("sweep_rand");
        if (bad != bad0) break;
        passes++;
      end
    end
    $display("sweep passes=%0d", passes);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL timeout obs=running exp=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule : tb_ahead_adder16
